rgmii_tx_framer: RTL
====================

// Module: rgmii_tx_framer
// PURPOSE
//  Transmit-side framer for the RGMII port: takes MAC payload bytes on a valid/ready stream and builds
//  the Ethernet frame (preamble, SFD, payload, zero pad, CRC-32 FCS, inter-frame gap).
//  Emits per-cycle nibble pairs and control bits for the external ODDR primitives that drive
//  RGMII_TX_D/RGMII_TX_CTL. Counterpart of the RX path; sits between the MAC stream and the I/O ring.
// PARAMETERS
//  IFG_BYTES    12  idle byte times enforced after each frame's TX_EN falls (>=1)
//  MIN_PAYLOAD  60  payload+pad length before FCS; shorter payloads zero-padded; 0 disables padding
// PORTS
//  RGMII_TX_CLK  in   1   125 MHz transmit clock; all logic on rising edge
//  RESET         in   1   synchronous, active-high reset
//  S_TDATA       in   8   payload byte
//  S_TVALID      in   1   S_TDATA valid
//  S_TLAST       in   1   last payload byte of frame
//  S_TREADY      out  1   byte accepted when S_TVALID&S_TREADY
//  TX_D_RISE     out  4   low nibble, to ODDR rising-edge input
//  TX_D_FALL     out  4   high nibble, to ODDR falling-edge input
//  TX_CTL_RISE   out  1   TX_EN
//  TX_CTL_FALL   out  1   TX_EN xor TX_ER
//  BUSY          out  1   state != IDLE
//  FRAME_CNT     out  16  frames completed with FCS, wraps 0xFFFF->0
//  ERR_CNT       out  16  frames aborted on underflow, wraps
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (S_TREADY=0, TX_*=0, counters=0). Reset mid-frame: outputs 0 from
//   the next edge; the frame is truncated, not counted; no IFG is enforced after reset.
//  Outputs registered; TX_* reflect the state/byte from the previous cycle (1-cycle latency).
//  States: IDLE -> PREAMBLE -> SFD -> PAYLOAD -> [PAD] -> FCS -> IFG -> IDLE; PAYLOAD -> ABORT -> IFG.
//  IDLE: S_TREADY=0; S_TVALID=1 -> PREAMBLE next cycle (the byte is held, not consumed).
//  PREAMBLE: 7 bytes 0x55; SFD: 1 byte 0xD5. TX_EN=1 for all.
//  PAYLOAD: S_TREADY=1; each accepted byte is transmitted and fed to the CRC; 16-bit byte counter.
//   S_TLAST accepted: count<MIN_PAYLOAD -> PAD, else -> FCS.
//  PAD: 0x00 bytes until count==MIN_PAYLOAD, included in CRC.
//  FCS: CRC-32, reflected poly 0xEDB88320, init 0xFFFFFFFF over payload+pad; send ~crc LSB byte first.
//   After byte 4: FRAME_CNT++ -> IFG.
//  Underflow (PAYLOAD, S_TVALID=0): emit one byte 0x00 with TX_EN=1, TX_ER=1
//   (TX_CTL_RISE=1, TX_CTL_FALL=0); ERR_CNT++ -> ABORT.
//  ABORT: TX_EN=0, S_TREADY=1, discard bytes through S_TLAST, then -> IFG.
//   S_TLAST arriving on the underflow cycle is impossible (no valid byte).
//  IFG: TX_EN=0, TX_D=0 for IFG_BYTES cycles, S_TREADY=0 -> IDLE; a pending S_TVALID starts the next
//   preamble on the following cycle. Gap between frames is therefore IFG_BYTES+1 idle cycles.
//  Outside a frame: TX_CTL_*=0, TX_D_*=0. TX_ER is never asserted except on underflow.
// TESTING
//  T1: 60-byte frame 0x00..0x3B -> 7x0x55, 0xD5, payload, 4 FCS bytes matching the bench CRC model;
//      TX_EN high exactly 72 cycles; FRAME_CNT=1.
//  T2: 1-byte frame 0xA5 -> 0xA5 + 59x0x00 pad, FCS over 60 bytes; 72 TX_EN cycles; S_TREADY for 1 beat.
//  T3: MIN_PAYLOAD=0, payload ASCII "123456789" -> FCS bytes 0x26,0x39,0xF4,0xCB; 21 TX_EN cycles.
//  T4: two 64-byte frames with S_TVALID held -> exactly 13 idle cycles between TX_EN fall and rise;
//      FRAME_CNT=2.
//  T5: S_TVALID dropped after payload byte 10 -> one cycle TX_CTL_RISE=1/FALL=0, then TX_EN=0;
//      rest consumed until S_TLAST; ERR_CNT=1, FRAME_CNT unchanged; next frame clean.
//  T6: RESET pulsed at payload byte 20 -> next edge all outputs 0; a following 60-byte frame is
//      correct with counters at 0.

Source files
------------

// File: rtl/rgmii_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : rgmii_tx_framer
//  Description : RGMII transmit framer. Wraps MAC payload bytes taken from a
//                valid/ready stream into an Ethernet frame made of preamble,
//                SFD, payload, zero pad, CRC-32 FCS and inter-frame gap.
//                Drives per-cycle nibble pairs and control bits to the ODDR
//                primitives in the I/O ring.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgmii_tx_framer #(
    parameter int IFG_BYTES   = 12,
    parameter int MIN_PAYLOAD = 60
) (
    input  logic        RGMII_TX_CLK,
    input  logic        RESET,
    input  logic [7:0]  S_TDATA,
    input  logic        S_TVALID,
    input  logic        S_TLAST,
    output logic        S_TREADY,
    output logic [3:0]  TX_D_RISE,
    output logic [3:0]  TX_D_FALL,
    output logic        TX_CTL_RISE,
    output logic        TX_CTL_FALL,
    output logic        BUSY,
    output logic [15:0] FRAME_CNT,
    output logic [15:0] ERR_CNT
);

    localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [15:0] PREAMBLE_END = 16'd6;
    localparam logic [15:0] FCS_END      = 16'd3;
    localparam logic [15:0] IFG_END      = 16'(IFG_BYTES - 1);
    localparam logic [16:0] MIN_LEN      = 17'(MIN_PAYLOAD);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_ABORT    = 3'd6,
        ST_IFG      = 3'd7
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [31:0] crc;
    logic [31:0] crc_nxt;
    logic [31:0] fcs_shift;
    logic [7:0]  d_nxt;
    logic        en_nxt;
    logic        er_nxt;
    logic        frame_inc;
    logic        err_inc;
    logic        pad_needed;
    logic        pad_done;

    // One byte of the reflected CRC-32 update, LSB of the data first
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Byte count after the current one still short of the minimum length
    assign pad_needed = ({1'b0, cnt} + 17'd1) < MIN_LEN;
    assign pad_done   = ({1'b0, cnt} + 17'd1) >= MIN_LEN;
    // FCS is the complemented CRC, least-significant byte on the wire first
    assign fcs_shift  = (~crc) >> {cnt[1:0], 3'b000};
    assign BUSY       = (state != ST_IDLE);

    // Next-state, next byte on the wire and counter updates
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        crc_nxt   = crc;
        d_nxt     = 8'h00;
        en_nxt    = 1'b0;
        er_nxt    = 1'b0;
        frame_inc = 1'b0;
        err_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                // The waiting byte is only looked at here, not consumed
                if (S_TVALID) begin
                    state_nxt = ST_PREAMBLE;
                    cnt_nxt   = 16'd0;
                end
            end
            ST_PREAMBLE: begin
                d_nxt  = 8'h55;
                en_nxt = 1'b1;
                if (cnt == PREAMBLE_END) begin
                    state_nxt = ST_SFD;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ST_SFD: begin
                d_nxt     = 8'hD5;
                en_nxt    = 1'b1;
                state_nxt = ST_PAYLOAD;
                cnt_nxt   = 16'd0;
                crc_nxt   = CRC_INIT;
            end
            ST_PAYLOAD: begin
                en_nxt = 1'b1;
                if (S_TVALID) begin
                    d_nxt   = S_TDATA;
                    crc_nxt = crc_byte(crc, S_TDATA);
                    cnt_nxt = cnt + 16'd1;
                    if (S_TLAST) begin
                        if (pad_needed) begin
                            state_nxt = ST_PAD;
                        end else begin
                            state_nxt = ST_FCS;
                            cnt_nxt   = 16'd0;
                        end
                    end
                end else begin
                    // Source ran dry mid-frame: poison the frame with TX_ER
                    er_nxt    = 1'b1;
                    err_inc   = 1'b1;
                    state_nxt = ST_ABORT;
                end
            end
            ST_PAD: begin
                en_nxt  = 1'b1;
                crc_nxt = crc_byte(crc, 8'h00);
                if (pad_done) begin
                    state_nxt = ST_FCS;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ST_FCS: begin
                d_nxt  = fcs_shift[7:0];
                en_nxt = 1'b1;
                if (cnt == FCS_END) begin
                    state_nxt = ST_IFG;
                    cnt_nxt   = 16'd0;
                    frame_inc = 1'b1;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            ST_ABORT: begin
                // Drain the rest of the broken frame silently
                if (S_TVALID && S_TLAST) begin
                    state_nxt = ST_IFG;
                    cnt_nxt   = 16'd0;
                end
            end
            ST_IFG: begin
                if (cnt == IFG_END) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge RGMII_TX_CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            cnt         <= 16'd0;
            crc         <= 32'd0;
            S_TREADY    <= 1'b0;
            TX_D_RISE   <= 4'd0;
            TX_D_FALL   <= 4'd0;
            TX_CTL_RISE <= 1'b0;
            TX_CTL_FALL <= 1'b0;
            FRAME_CNT   <= 16'd0;
            ERR_CNT     <= 16'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            crc         <= crc_nxt;
            S_TREADY    <= (state_nxt == ST_PAYLOAD) || (state_nxt == ST_ABORT);
            TX_D_RISE   <= d_nxt[3:0];
            TX_D_FALL   <= d_nxt[7:4];
            TX_CTL_RISE <= en_nxt;
            TX_CTL_FALL <= en_nxt ^ er_nxt;
            if (frame_inc) begin
                FRAME_CNT <= FRAME_CNT + 16'd1;
            end
            if (err_inc) begin
                ERR_CNT <= ERR_CNT + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
